// File: rtl/piso_module_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter: FSM encoding and default word width.
package piso_module_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_module.sv
// Parallel-in/serial-out shifter: loads D on Start, streams it out on SO with stall (Hold),
// and pulses Done for one cycle after the last bit. All outputs are registered.
module piso_module
    import piso_module_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [WIDTH-1:0] D,
    input  logic             Hold,
    output logic             SO,
    output logic             SValid,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Bit 0 is presented on the capture edge itself so bit k lands in cycle S+1+k;
    // cnt therefore holds the index of the bit currently on SO.
    always_ff @(posedge CLK or negedge Clrn) begin
        if (!Clrn) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            Q      <= '0;
            SO     <= 1'b0;
            SValid <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done   <= 1'b0;
                    SValid <= 1'b0;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                    if (Start) begin
                        sr     <= advance(D);
                        Q      <= D;
                        SO     <= first_bit(D);
                        SValid <= 1'b1;
                        Busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (Hold) begin
                        SValid <= 1'b0;
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        Done   <= 1'b1;
                        Busy   <= 1'b0;
                        SValid <= 1'b0;
                    end else begin
                        SO     <= first_bit(sr);
                        sr     <= advance(sr);
                        cnt    <= cnt + CW'(1);
                        SValid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_module.sv
// Bench for piso_module: MSB-first and LSB-first instances share stimulus and are checked
// every cycle against a queue-based model, plus literal expectations per directed word.
module tb_piso_module;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] d = 8'h00;

    logic       so1, sv1, busy1, done1;
    logic       so0, sv0, busy0, done0;
    logic [7:0] q1, q0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_module #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .CLK(clk), .Clrn(rst_n), .Start(start), .D(d), .Hold(hold),
        .SO(so1), .SValid(sv1), .Busy(busy1), .Done(done1), .Q(q1)
    );

    piso_module #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .CLK(clk), .Clrn(rst_n), .Start(start), .D(d), .Hold(hold),
        .SO(so0), .SValid(sv0), .Busy(busy0), .Done(done0), .Q(q0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a word is a list of pending bits; each unstalled edge pops one,
    // an empty list on an unstalled edge produces the Done cycle.
    logic       m_so1 = 1'b0, m_so0 = 1'b0, m_sv = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [7:0] m_q = 8'h00;
    bit         pm[$];
    bit         pl[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_so1 <= 1'b0; m_so0 <= 1'b0; m_sv <= 1'b0;
            m_busy <= 1'b0; m_done <= 1'b0; m_q <= 8'h00;
            pm.delete(); pl.delete();
        end else if (m_busy) begin
            if (hold) begin
                m_sv <= 1'b0;
            end else if (pm.size() == 0) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_sv <= 1'b0;
            end else begin
                m_so1 <= pm.pop_front();
                m_so0 <= pl.pop_front();
                m_sv  <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            m_sv   <= 1'b0;
            if (start) begin
                for (int i = 1; i < 8; i++) begin
                    pm.push_back(d[7-i]);
                    pl.push_back(d[i]);
                end
                m_so1 <= d[7]; m_so0 <= d[0]; m_sv <= 1'b1;
                m_busy <= 1'b1; m_q <= d;
            end
        end
    end

    always @(negedge clk) begin
        chk("so_msb",  {31'd0, so1},    {31'd0, m_so1});
        chk("so_lsb",  {31'd0, so0},    {31'd0, m_so0});
        chk("sv_msb",  {31'd0, sv1},    {31'd0, m_sv});
        chk("sv_lsb",  {31'd0, sv0},    {31'd0, m_sv});
        chk("busy",    {30'd0, busy1, busy0}, {30'd0, m_busy, m_busy});
        chk("done",    {30'd0, done1, done0}, {30'd0, m_done, m_done});
        chk("q",       {16'd0, q1, q0}, {16'd0, m_q, m_q});
    end

    // Called at a negedge; leaves the bench at the negedge of cycle s+1.
    task automatic pulse_start(input logic [7:0] dv, output int s);
        start = 1'b1;
        d = dv;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        d = ~dv;
    endtask

    // Watches the word from cycle s+1 until Done; returns at the negedge of the Done cycle.
    task automatic collect(input int s, input int hs, input int hl, input int xs,
                           output logic [7:0] wm, output logic [7:0] wl,
                           output int n, output int dc);
        int rel;
        wm = 8'h00; wl = 8'h00; n = 0; dc = -1;
        for (int k = 0; k < 30; k++) begin
            rel = cyc - s;
            if (rel == hs) hold = 1'b1;
            if (rel == hs + hl) hold = 1'b0;
            if (rel == xs) begin start = 1'b1; d = 8'hFF; end
            if (rel == xs + 1) begin start = 1'b0; d = 8'h00; end
            if (sv1) begin
                wm = {wm[6:0], so1};
                wl = {so0, wl[7:1]};
                n++;
            end
            if (done1) begin
                dc = rel;
                break;
            end
            @(negedge clk);
        end
        hold = 1'b0;
        start = 1'b0;
    endtask

    int s, s2, n, dc, nd;
    logic [7:0] wm, wl;

    initial begin
        #1;
        chk("rst_outs", {28'd0, so1, sv1, busy1, done1}, 32'd0);
        chk("rst_q", {16'd0, q1, q0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Plain A5 word, both bit orders
        pulse_start(8'hA5, s);
        collect(s, -10, 0, -10, wm, wl, n, dc);
        chk("a5_msb_bits", {24'd0, wm}, 32'h0000_00A5);
        chk("a5_lsb_bits", {24'd0, wl}, 32'h0000_00A5);
        chk("a5_nbits", n, 32'd8);
        chk("a5_done_cyc", dc, 32'd9);
        chk("a5_q", {16'd0, q1, q0}, 32'h0000_A5A5);
        @(negedge clk);
        @(negedge clk);

        // 3C with a two-cycle stall after bit 2
        pulse_start(8'h3C, s);
        collect(s, 3, 2, -10, wm, wl, n, dc);
        chk("3c_msb_bits", {24'd0, wm}, 32'h0000_003C);
        chk("3c_lsb_bits", {24'd0, wl}, 32'h0000_003C);
        chk("3c_nbits", n, 32'd8);
        chk("3c_done_cyc", dc, 32'd11);
        @(negedge clk);

        // Start ignored mid-word, then back-to-back start in the Done cycle
        pulse_start(8'h00, s);
        collect(s, -10, 0, 3, wm, wl, n, dc);
        chk("00_bits", {24'd0, wm}, 32'h0000_0000);
        chk("00_q", {24'd0, q1}, 32'h0000_0000);
        chk("00_done_cyc", dc, 32'd9);
        pulse_start(8'h81, s2);
        chk("81_no_gap", s2 - s, 32'd9);
        chk("81_first_valid", {30'd0, sv1, so1}, 32'd3);
        collect(s2, -10, 0, -10, wm, wl, n, dc);
        chk("81_msb_bits", {24'd0, wm}, 32'h0000_0081);
        chk("81_lsb_bits", {24'd0, wl}, 32'h0000_0081);
        chk("81_done_cyc", dc, 32'd9);
        chk("81_q", {24'd0, q0}, 32'h0000_0081);
        @(negedge clk);

        // Hold asserted while idle and in the Start cycle has no effect
        hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pulse_start(8'hC3, s);
        collect(s, 0, 1, -10, wm, wl, n, dc);
        chk("c3_bits", {24'd0, wm}, 32'h0000_00C3);
        chk("c3_nbits", n, 32'd8);
        chk("c3_done_cyc", dc, 32'd9);
        @(negedge clk);

        // Asynchronous reset after 3 bits, then a clean word
        pulse_start(8'hA5, s);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs", {24'd0, so1, sv1, busy1, done1, so0, sv0, busy0, done0}, 32'd0);
        chk("abort_q", {16'd0, q1, q0}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("release_outs", {28'd0, so1, sv1, busy1, done1}, 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1 || done0 || busy1) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        pulse_start(8'h0F, s);
        collect(s, -10, 0, -10, wm, wl, n, dc);
        chk("0f_msb_bits", {24'd0, wm}, 32'h0000_000F);
        chk("0f_lsb_bits", {24'd0, wl}, 32'h0000_000F);
        chk("0f_done_cyc", dc, 32'd9);
        chk("0f_q", {24'd0, q1}, 32'h0000_000F);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
